// File: rtl/rv32_pipe_skid_stage.sv
// Elastic valid/ready pipeline register with optional two-entry skid buffer and synchronous flush.
// One instance sits between each pair of rv32 pipeline stages and carries that stage's packed struct.
module rv32_pipe_skid_stage #(
  parameter int unsigned      WIDTH     = 32,
  parameter bit               SKID_EN   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q;
  logic             accept;
  logic             emit;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  // Skid mode uses the registered ready so out_ready never reaches in_ready combinationally.
  assign in_ready = ~rst & (SKID_EN ? rdy_q : (~out_valid | out_ready));
  assign accept   = in_valid & in_ready;
  assign emit     = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (emit) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      rdy_q   <= (state_d != TWO);
    end
  end

  // Overflow entry is only read while state_q is TWO, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule
